mat_vec_sequencer: RTL and testbench

// - Controller for the 8x8-matrix x 8x1-vector MAC datapath: the A-row FIFOs,
//   the B-vector FIFO, the B shift register and the MAC array.
// - Accepts one serial operand stream and steers each word into the correct FIFO.
// - Waits for all FIFOs full, then issues skewed per-row read enables and
//   per-row MAC enables so row r multiplies A[r][c] by B[c].
// - Clears the MACs before each job and pulses done once results are final.
//

---
 rtl/mat_vec_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mat_vec_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_vec_sequencer.sv
// Sequencer for the 8x8 matrix x vector MAC datapath: steers operands into FIFOs and drives skewed reads and MAC enables.
// Optional build macro MAT_VEC_SEQ_TIMEOUT_EN adds a 16-cycle timeout on the wait-for-full phase.
module mat_vec_sequencer #(
  parameter int DEPTH      = 8,
  parameter int ROWS       = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic [ROWS-1:0]       a_wren,
  output logic                  b_wren,
  input  logic [ROWS-1:0]       a_full,
  input  logic [ROWS-1:0]       a_empty,
  input  logic                  b_full,
  input  logic                  b_empty,
  output logic [ROWS-1:0]       a_rden,
  output logic                  b_rden,
  output logic [ROWS-1:0]       mac_en,
  output logic                  mac_clr
);

  localparam int TOTAL = DEPTH + ROWS * DEPTH;
  localparam int KW    = $clog2(TOTAL);
  localparam int TLAST = DEPTH + ROWS - 2;
  localparam int TW    = $clog2(TLAST + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_WAIT_FULL, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [TW-1:0]   t;
`ifdef MAT_VEC_SEQ_TIMEOUT_EN
  logic [3:0]      wait_cnt;
`endif

  logic            to_b;
  logic [ROWS-1:0] a_sel;
  logic            tgt_full;
  logic            load_xfer;
  logic            drop;

  // Target FIFO for the current word: first DEPTH words are B, then A row-major.
  always_comb begin
    to_b     = (int'(k) < DEPTH);
    a_sel    = '0;
    tgt_full = b_full;
    for (int r = 0; r < ROWS; r++) begin
      if (!to_b && ((int'(k) - DEPTH) / DEPTH == r)) begin
        a_sel[r] = 1'b1;
        tgt_full = a_full[r];
      end
    end
  end

  assign load_xfer  = (state == S_LOAD) && in_valid;
  assign drop       = load_xfer && tgt_full;
  assign b_wren     = load_xfer && to_b && !b_full;
  assign a_wren     = (load_xfer && !tgt_full) ? a_sel : '0;
  assign fifo_wdata = in_data;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign mac_clr  = (state == S_CLR);

  // Row r lags the B stream by r cycles so it meets B[c] in the shift register.
  always_comb begin
    a_rden = '0;
    b_rden = (state == S_RUN) && (int'(t) < DEPTH);
    for (int r = 0; r < ROWS; r++) begin
      a_rden[r] = (state == S_RUN) && (int'(t) >= r) && (int'(t) < r + DEPTH);
    end
  end

  // mac_en trails a_rden by one cycle because FIFO data appears the cycle after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_en <= '0;
    end else begin
      mac_en <= a_rden;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      k        <= '0;
      t        <= '0;
      err      <= 1'b0;
`ifdef MAT_VEC_SEQ_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CLR;
            err   <= 1'b0;
          end
        end
        S_CLR: begin
          state <= S_LOAD;
          k     <= '0;
        end
        S_LOAD: begin
          if (in_valid) begin
            if (drop) err <= 1'b1;
            if (k == KW'(TOTAL - 1)) begin
              state <= S_WAIT_FULL;
`ifdef MAT_VEC_SEQ_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_WAIT_FULL: begin
          if ((&a_full) && b_full) begin
            state <= S_RUN;
            t     <= '0;
          end
`ifdef MAT_VEC_SEQ_TIMEOUT_EN
          else if (wait_cnt == 4'hF) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RUN: begin
          if (t == TW'(TLAST)) state <= S_DRAIN;
          else                 t     <= t + 1'b1;
        end
        S_DRAIN: begin
          if ((&a_empty) && b_empty) begin
            state <= S_DONE;
          end else begin
            err   <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_vec_sequencer.sv
// Directed bench for mat_vec_sequencer with behavioural FIFOs, B delay line and MAC array around it.
module tb_mat_vec_sequencer;
  localparam int D = 8;
  localparam int R = 8;
  localparam int W = 8;
  localparam int TOTAL = D + R * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic busy, done, err, in_ready, b_wren, b_rden, mac_clr;
  logic [W-1:0] fifo_wdata;
  logic [R-1:0] a_wren, a_rden, mac_en, a_full, a_empty;
  logic b_full, b_empty;

  bit force_bfull = 0, force_bnempty = 0, tie_a3 = 0;

  mat_vec_sequencer #(.DEPTH(D), .ROWS(R), .DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .fifo_wdata(fifo_wdata),
    .a_wren(a_wren), .b_wren(b_wren), .a_full(a_full), .a_empty(a_empty),
    .b_full(b_full), .b_empty(b_empty), .a_rden(a_rden), .b_rden(b_rden),
    .mac_en(mac_en), .mac_clr(mac_clr)
  );

  always #5 clk = ~clk;

  // FIFO models: data appears on *_q the cycle after a read
  logic [W-1:0] amem [R][D];
  logic [W-1:0] bmem [D];
  int acnt [R], awp [R], arp [R];
  int bcnt, bwp, brp;
  logic [W-1:0] a_q [R];
  logic [W-1:0] b_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < R; r++) begin
        acnt[r] <= 0; awp[r] <= 0; arp[r] <= 0; a_q[r] <= '0;
      end
      bcnt <= 0; bwp <= 0; brp <= 0; b_q <= '0;
    end else begin
      for (int r = 0; r < R; r++) begin
        if (a_wren[r] && acnt[r] < D) begin
          amem[r][awp[r]] <= fifo_wdata;
          awp[r] <= (awp[r] + 1) % D;
        end
        if (a_rden[r] && acnt[r] > 0) begin
          a_q[r] <= amem[r][arp[r]];
          arp[r] <= (arp[r] + 1) % D;
        end
        acnt[r] <= acnt[r] + ((a_wren[r] && acnt[r] < D) ? 1 : 0) - ((a_rden[r] && acnt[r] > 0) ? 1 : 0);
      end
      if (b_wren && bcnt < D) begin
        bmem[bwp] <= fifo_wdata;
        bwp <= (bwp + 1) % D;
      end
      if (b_rden && bcnt > 0) begin
        b_q <= bmem[brp];
        brp <= (brp + 1) % D;
      end
      bcnt <= bcnt + ((b_wren && bcnt < D) ? 1 : 0) - ((b_rden && bcnt > 0) ? 1 : 0);
    end
  end

  always_comb begin
    a_full = '0;
    a_empty = '0;
    for (int r = 0; r < R; r++) begin
      a_full[r]  = (acnt[r] == D) && !(tie_a3 && r == 3);
      a_empty[r] = (acnt[r] == 0);
    end
    b_full  = (bcnt == D) || force_bfull;
    b_empty = (bcnt == 0) && !force_bnempty;
  end

  // B delay line and MAC array
  logic [W-1:0] bsh [R];
  logic [23:0] acc [R];
  always @(posedge clk) begin
    for (int r = 1; r < R; r++) bsh[r] <= (r == 1) ? b_q : bsh[r-1];
    for (int r = 0; r < R; r++) begin
      if (mac_clr) acc[r] <= '0;
      else if (mac_en[r]) acc[r] <= acc[r] + 24'(a_q[r]) * 24'((r == 0) ? b_q : bsh[r]);
    end
  end

  logic [W-1:0] Am [R][D];
  logic [W-1:0] Bv [D];
  logic [W-1:0] words [TOTAL];
  int n_assert = 0, n_fail = 0;
  int last_rdy, last_wr, last_bad_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_out(input int r);
    logic [23:0] s = '0;
    for (int c = 0; c < D; c++) s = s + 24'(Am[r][c]) * 24'(Bv[c]);
    return s;
  endfunction

  task automatic build_words();
    for (int c = 0; c < D; c++) words[c] = Bv[c];
    for (int r = 0; r < R; r++)
      for (int c = 0; c < D; c++) words[D + r * D + c] = Am[r][c];
  endtask

  task automatic load_words(input bit gap);
    int idx = 0;
    bit xfer = 0;
    last_rdy = 0; last_wr = 0; last_bad_wr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (xfer) idx++;
      if (idx == TOTAL) break;
      in_valid = gap ? (cyc % 2 == 1) : 1'b1;
      in_data = words[idx];
      #1;
      if (in_ready) last_rdy++;
      if ((|a_wren) || b_wren) begin
        last_wr++;
        if (!in_valid) last_bad_wr++;
      end
      xfer = in_ready && in_valid;
    end
    in_valid = 1'b0;
    chk("load_complete", idx, TOTAL);
  endtask

  task automatic run_job(input bit gap, input bit poke, input int rst_at,
                         input bit exp_done, input bit exp_err, input bit check_res);
    logic [R-1:0] ea, em;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("clr_mac_clr", mac_clr, 1);
    chk("clr_busy", busy, 1);
    chk("clr_err_cleared", err, 0);
    build_words();
    load_words(gap);
    chk("wait_in_ready_low", in_ready, 0);
    for (int n = 0; n < 20 && !b_rden; n++) @(negedge clk);
    chk("reach_run", b_rden, 1);
    for (int k = 0; k < 18; k++) begin
      if (rst_at == k) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_outputs", {done, err, in_ready, b_wren, b_rden, mac_clr, a_wren, a_rden, mac_en}, 0);
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      start = (poke && k == 3);
      for (int r = 0; r < R; r++) begin
        ea[r] = (k >= r) && (k < r + D) && (k <= 14);
        em[r] = (k >= r + 1) && (k <= r + D);
      end
      chk($sformatf("a_rden_k%0d", k), a_rden, ea);
      chk($sformatf("b_rden_k%0d", k), b_rden, k < D);
      chk($sformatf("mac_en_k%0d", k), mac_en, em);
      chk($sformatf("done_k%0d", k), done, exp_done && k == 16);
      chk($sformatf("busy_k%0d", k), busy, (k <= 15) || (exp_done && k == 16));
      @(negedge clk);
    end
    start = 1'b0;
    chk("job_err", err, exp_err);
    if (check_res)
      for (int r = 0; r < R; r++) chk($sformatf("out_row%0d", r), acc[r], ref_out(r));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with in_valid high to show it causes no writes
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_outputs", {done, err, in_ready, b_wren, b_rden, mac_clr, a_wren, a_rden, mac_en}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_write", {in_ready, b_wren, a_wren}, 0);
    chk("fifo_wdata_pass", fifo_wdata, in_data);
    in_valid = 1'b0;

    // Identity: out[r] = r+1
    for (int r = 0; r < R; r++)
      for (int c = 0; c < D; c++) Am[r][c] = (r == c) ? 8'd1 : 8'd0;
    for (int c = 0; c < D; c++) Bv[c] = 8'(c + 1);
    run_job(0, 0, -1, 1, 0, 1);
    chk("ident_ready_cycles", last_rdy, 72);
    chk("ident_out7", acc[7], 8);

    // All ones, with a start pulse during RUN that must be ignored
    for (int r = 0; r < R; r++)
      for (int c = 0; c < D; c++) Am[r][c] = 8'd1;
    for (int c = 0; c < D; c++) Bv[c] = 8'd1;
    run_job(0, 1, -1, 1, 0, 1);
    chk("ones_out0", acc[0], 8);
    chk("ones_stays_idle", busy, 0);

    // Backpressure with mixed values
    for (int r = 0; r < R; r++)
      for (int c = 0; c < D; c++) Am[r][c] = 8'((r * 37 + c * 11 + 5) % 256);
    for (int c = 0; c < D; c++) Bv[c] = 8'(250 - c * 3);
    run_job(1, 0, -1, 1, 0, 1);
    chk("gap_write_count", last_wr, 72);
    chk("gap_no_write_invalid", last_bad_wr, 0);

    // Reset mid-RUN at t=5, then a clean identity job
    run_job(0, 0, 5, 1, 0, 0);
    chk("post_rst_idle", busy, 0);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < D; c++) Am[r][c] = (r == c) ? 8'd1 : 8'd0;
    for (int c = 0; c < D; c++) Bv[c] = 8'(c + 1);
    run_job(0, 0, -1, 1, 0, 1);

    // B FIFO reports full throughout: B words dropped, err set, job still completes
    force_bfull = 1;
    run_job(0, 0, -1, 1, 1, 0);
    force_bfull = 0;
    chk("drop_write_count", last_wr, 64);
    chk("drop_err_sticky", err, 1);

    // B FIFO not empty at DRAIN: err and no done
    force_bnempty = 1;
    run_job(0, 0, -1, 0, 1, 0);
    force_bnempty = 0;

    // Next job clears err on start and computes correctly
    run_job(0, 0, -1, 1, 0, 1);

`ifdef MAT_VEC_SEQ_TIMEOUT_EN
    begin
      int wcnt = 0;
      bit saw_done = 0;
      tie_a3 = 1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      build_words();
      load_words(0);
      for (int n = 0; n < 40 && busy; n++) begin
        if (done) saw_done = 1;
        wcnt++;
        @(negedge clk);
      end
      chk("timeout_cycles", wcnt, 16);
      chk("timeout_err", err, 1);
      chk("timeout_busy", busy, 0);
      chk("timeout_no_done", saw_done, 0);
      tie_a3 = 0;
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
    end
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
